hex_display_scanner: RTL and testbench
======================================

Name: hex_display_scanner

Overview:
- Decodes an 8-bit value into two time-multiplexed seven-segment hex digits. Acts as the output-side counterpart of the keypad encoder: the encoder scans keys into hex codes, this block scans hex codes out to a display.
- Sits after the ALU/register bank. Drives segment and digit-select pins.
- New values are accepted on a load strobe and applied only at frame boundaries, so the display never tears.

Parameters:
- REFRESH_DIV, 16'd10000, clock cycles per digit slot; legal range >= 4.
- GUARD, 4, cycles at the start of each slot with all digits off (anti-ghosting); must be < REFRESH_DIV.
- COMMON_ANODE, 0, 1 = invert seg_out, dp_out and dig_sel at the pins.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- data_in  input  8  value to display; [3:0] goes to digit 0, [7:4] to digit 1
- dp_in  input  2  decimal points, bit i belongs to digit i; latched with data_in
- load  input  1  one-cycle strobe that captures data_in/dp_in into the pending register
- en  input  1  display enable; 0 turns all digits off
- blank_lz  input  1  leading-zero suppression for digit 1
- seg_out  output  7  segments {g,f,e,d,c,b,a}; bit0 = a; active-high before COMMON_ANODE inversion
- dp_out  output  1  decimal point of the active digit
- dig_sel  output  2  one-hot digit enable; 01 = digit 0, 10 = digit 1
- upd_ack  output  1  one-cycle pulse when the pending value becomes the displayed value

Behaviour:
- Reset (async, active-high):
  - refresh counter = 0; digit index = 0.
  - Displayed register = 0; pending register = 0; pending-valid flag = 0.
  - seg_out = 0, dp_out = 0, dig_sel = 00, upd_ack = 0, all at the logical level (inverted when COMMON_ANODE = 1).
- Refresh counter:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - On each wrap the digit index toggles 0 -> 1 -> 0.
  - A frame is two slots; the frame boundary is the wrap that returns the index to 0.
- Load handshake:
  - load = 1 captures data_in/dp_in into the pending register and sets pending-valid.
  - A second load before the frame boundary overwrites the pending value (last wins). No backpressure.
- Frame boundary with pending-valid = 1:
  - Displayed register <= pending register; pending-valid cleared.
  - upd_ack = 1 in the following cycle.
- Load in the same cycle as the frame boundary:
  - The already-pending value is applied at this boundary.
  - The new value is captured and stays pending for the next boundary.
  - If nothing was pending, only the new value is captured; it is not applied in that cycle.
- Decode table, nibble -> seg (logical, hex):
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- Digit selection:
  - dig_sel = 00 while counter < GUARD, and whenever en = 0.
  - Otherwise dig_sel is one-hot for the current index.
  - When dig_sel = 00, seg_out and dp_out are also forced to 0.
- Leading-zero suppression: blank_lz = 1 and displayed[7:4] = 0 -> digit 1 slot stays dark (dig_sel 00, seg 0). Digit 0 is never suppressed.
- Latency:
  - All outputs are registered: one cycle after the counter/index state that produces them.
  - Changes to en and blank_lz take effect one cycle later, mid-slot included.
- en = 0 does not stop the refresh counter or the load/apply logic.
- Reset mid-slot clears everything immediately. The first slot after reset is digit 0, starting at count 0.
- COMMON_ANODE = 1: the pins are the bitwise inverse of the logical values, including the reset values (seg 7F, dp 1, dig_sel 11).

Test Plan:
- Reset, then load data_in = 8'h00, with REFRESH_DIV = 8, GUARD = 2 -> for 2 cycles/slot dig_sel = 00, then dig_sel = 01 with seg 3F for 6 cycles, then the same for digit 1.
- Load 8'h3A with dp_in = 2'b01 mid-frame -> display unchanged until the frame boundary; upd_ack pulses once. Afterwards digit 0 shows seg 77 with dp 1, digit 1 shows seg 4F with dp 0.
- Load 8'h11 then 8'h5E within one frame -> only 8'h5E is displayed (seg 79 / 6D); exactly one upd_ack.
- blank_lz = 1 with value 8'h07 -> digit 1 slot dark (dig_sel 00), digit 0 shows 07. With blank_lz = 0, digit 1 shows 3F.
- en = 0 for one full frame, then en = 1 -> dig_sel stays 00 throughout; the slot phase continues as if uninterrupted. A load during en = 0 is still applied with upd_ack.
- COMMON_ANODE = 1, value 8'h8F -> digit-0 slot pins: dig_sel = 10 (inverted 01), seg = 0E (inverted 71). Assert reset mid-slot -> seg = 7F and dig_sel = 11 immediately.

Source files
------------

// File: rtl/hex_display_scanner.sv
// Two-digit time-multiplexed seven-segment hex driver. Loads are staged in a
// pending register and applied only at frame boundaries to avoid tearing.
`timescale 1ns/1ps
module hex_display_scanner #(
  parameter logic [15:0] REFRESH_DIV  = 16'd10000,
  parameter int          GUARD        = 4,
  parameter bit          COMMON_ANODE = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic [1:0] dp_in,
  input  logic       load,
  input  logic       en,
  input  logic       blank_lz,
  output logic [6:0] seg_out,
  output logic       dp_out,
  output logic [1:0] dig_sel,
  output logic       upd_ack
);

  localparam logic [15:0] CNT_LAST = REFRESH_DIV - 16'd1;
  localparam logic [15:0] GUARD_W  = 16'(GUARD);

  logic [15:0] cnt_q, cnt_d;
  logic        idx_q, idx_d;
  logic [7:0]  disp_q, disp_d;
  logic [1:0]  disp_dp_q, disp_dp_d;
  logic [7:0]  pend_q, pend_d;
  logic [1:0]  pend_dp_q, pend_dp_d;
  logic        pend_vld_q, pend_vld_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic [1:0]  dig_q, dig_d;
  logic        ack_q, ack_d;

  logic        wrap;
  logic        frame_end;
  logic [3:0]  nibble;
  logic [6:0]  seg_dec;
  logic        active;

  assign wrap      = (cnt_q == CNT_LAST);
  assign frame_end = wrap && idx_q;

  always_comb begin
    cnt_d = wrap ? 16'd0 : cnt_q + 16'd1;
    idx_d = wrap ? ~idx_q : idx_q;
  end

  // The pending value is applied before a same-cycle load overwrites it,
  // so a load at the boundary waits for the next frame.
  always_comb begin
    disp_d     = disp_q;
    disp_dp_d  = disp_dp_q;
    pend_d     = pend_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    ack_d      = 1'b0;
    if (frame_end && pend_vld_q) begin
      disp_d     = pend_q;
      disp_dp_d  = pend_dp_q;
      pend_vld_d = 1'b0;
      ack_d      = 1'b1;
    end
    if (load) begin
      pend_d     = data_in;
      pend_dp_d  = dp_in;
      pend_vld_d = 1'b1;
    end
  end

  always_comb begin
    nibble = idx_q ? disp_q[7:4] : disp_q[3:0];
    case (nibble)
      4'h0:    seg_dec = 7'h3F;
      4'h1:    seg_dec = 7'h06;
      4'h2:    seg_dec = 7'h5B;
      4'h3:    seg_dec = 7'h4F;
      4'h4:    seg_dec = 7'h66;
      4'h5:    seg_dec = 7'h6D;
      4'h6:    seg_dec = 7'h7D;
      4'h7:    seg_dec = 7'h07;
      4'h8:    seg_dec = 7'h7F;
      4'h9:    seg_dec = 7'h6F;
      4'hA:    seg_dec = 7'h77;
      4'hB:    seg_dec = 7'h7C;
      4'hC:    seg_dec = 7'h39;
      4'hD:    seg_dec = 7'h5E;
      4'hE:    seg_dec = 7'h79;
      default: seg_dec = 7'h71;
    endcase
  end

  // Guard interval, disable and leading-zero blanking all darken the slot.
  always_comb begin
    active = en && (cnt_q >= GUARD_W) &&
             !(idx_q && blank_lz && (disp_q[7:4] == 4'h0));
    seg_d  = active ? seg_dec : 7'h00;
    dp_d   = active ? disp_dp_q[idx_q] : 1'b0;
    dig_d  = active ? (idx_q ? 2'b10 : 2'b01) : 2'b00;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= 16'd0;
      idx_q      <= 1'b0;
      disp_q     <= 8'h00;
      disp_dp_q  <= 2'b00;
      pend_q     <= 8'h00;
      pend_dp_q  <= 2'b00;
      pend_vld_q <= 1'b0;
      seg_q      <= 7'h00;
      dp_q       <= 1'b0;
      dig_q      <= 2'b00;
      ack_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      disp_q     <= disp_d;
      disp_dp_q  <= disp_dp_d;
      pend_q     <= pend_d;
      pend_dp_q  <= pend_dp_d;
      pend_vld_q <= pend_vld_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      dig_q      <= dig_d;
      ack_q      <= ack_d;
    end
  end

  // Polarity is applied after the flops so reset values invert too.
  assign seg_out = seg_q ^ {7{COMMON_ANODE}};
  assign dp_out  = dp_q ^ COMMON_ANODE;
  assign dig_sel = dig_q ^ {2{COMMON_ANODE}};
  assign upd_ack = ack_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed self-checking bench for hex_display_scanner with an 8-cycle slot
// and a 2-cycle guard; a second instance checks common-anode polarity.
`timescale 1ns/1ps
module tb_hex_display_scanner;

  localparam int DIV = 8;
  localparam int GRD = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic [1:0] dp_in = 2'b00;
  logic       load = 1'b0;
  logic       en = 1'b1;
  logic       blank_lz = 1'b0;

  logic [6:0] seg_out, seg_ca;
  logic       dp_out, dp_ca;
  logic [1:0] dig_sel, dig_ca;
  logic       upd_ack, ack_ca;

  int cyc = 0;
  int ack_cnt = 0;
  int pass_cnt = 0;
  int total_cnt = 0;
  int ack_base = 0;

  hex_display_scanner #(.REFRESH_DIV(16'd8), .GUARD(2), .COMMON_ANODE(1'b0)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .dp_in(dp_in), .load(load),
    .en(en), .blank_lz(blank_lz), .seg_out(seg_out), .dp_out(dp_out),
    .dig_sel(dig_sel), .upd_ack(upd_ack)
  );

  hex_display_scanner #(.REFRESH_DIV(16'd8), .GUARD(2), .COMMON_ANODE(1'b1)) dut_ca (
    .clk(clk), .reset(reset), .data_in(data_in), .dp_in(dp_in), .load(load),
    .en(en), .blank_lz(blank_lz), .seg_out(seg_ca), .dp_out(dp_ca),
    .dig_sel(dig_ca), .upd_ack(ack_ca)
  );

  always #5 clk = ~clk;

  // Bench-side cycle count since reset release; outputs at cycle k reflect slot state k-1.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (!reset && upd_ack) ack_cnt <= ack_cnt + 1;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycle(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic apply_load(input logic [7:0] d, input logic [1:0] dp);
    data_in = d;
    dp_in   = dp;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
  endtask

  // Checks every cycle in [k0,k1] against the expected slot contents.
  task automatic check_span(input int k0, input int k1,
                            input logic [6:0] seg0, input logic dp0,
                            input logic [6:0] seg1, input logic dp1,
                            input bit dark0, input bit dark1);
    for (int k = k0; k <= k1; k++) begin
      int  s, c, i;
      bit  dark;
      logic [6:0] es;
      logic       ed;
      logic [1:0] eg;
      wait_cycle(k);
      s    = k - 1;
      c    = s % DIV;
      i    = (s / DIV) % 2;
      dark = (c < GRD) || (i == 1 ? dark1 : dark0);
      es   = dark ? 7'h00 : (i == 1 ? seg1 : seg0);
      ed   = dark ? 1'b0 : (i == 1 ? dp1 : dp0);
      eg   = dark ? 2'b00 : (i == 1 ? 2'b10 : 2'b01);
      check_output($sformatf("dig_sel@%0d", k), 8'(dig_sel), 8'(eg));
      check_output($sformatf("seg_out@%0d", k), 8'(seg_out), 8'(es));
      check_output($sformatf("dp_out@%0d", k), 8'(dp_out), 8'(ed));
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_output("rst_seg", 8'(seg_out), 8'h00);
    check_output("rst_dig", 8'(dig_sel), 8'h00);
    check_output("rst_dp", 8'(dp_out), 8'h00);
    check_output("rst_ack", 8'(upd_ack), 8'h00);
    check_output("rst_seg_ca", 8'(seg_ca), 8'h7F);
    check_output("rst_dig_ca", 8'(dig_ca), 8'h03);
    check_output("rst_dp_ca", 8'(dp_ca), 8'h01);
    reset = 1'b0;

    // Load zero, first frame shows 0 on both digits with guard gaps.
    apply_load(8'h00, 2'b00);
    check_span(1, 16, 7'h3F, 1'b0, 7'h3F, 1'b0, 1'b0, 1'b0);
    check_output("ack_first", 8'(upd_ack), 8'h01);
    wait_cycle(17);
    check_output("ack_first_end", 8'(upd_ack), 8'h00);

    // Mid-frame load held until the boundary.
    wait_cycle(20);
    apply_load(8'h3A, 2'b01);
    check_span(21, 31, 7'h3F, 1'b0, 7'h3F, 1'b0, 1'b0, 1'b0);
    check_output("ack_3a_early", 8'(upd_ack), 8'h00);
    check_span(32, 32, 7'h3F, 1'b0, 7'h3F, 1'b0, 1'b0, 1'b0);
    check_output("ack_3a", 8'(upd_ack), 8'h01);
    check_span(33, 48, 7'h77, 1'b1, 7'h4F, 1'b0, 1'b0, 1'b0);

    // Two loads in one frame: last wins, single ack.
    ack_base = ack_cnt;
    wait_cycle(50);
    apply_load(8'h11, 2'b00);
    wait_cycle(55);
    apply_load(8'h5E, 2'b00);
    check_span(56, 64, 7'h77, 1'b1, 7'h4F, 1'b0, 1'b0, 1'b0);
    check_span(65, 80, 7'h79, 1'b0, 7'h6D, 1'b0, 1'b0, 1'b0);
    check_output("ack_count_last_wins", 8'(ack_cnt - ack_base), 8'd1);

    // Leading-zero suppression on digit 1.
    wait_cycle(82);
    blank_lz = 1'b1;
    apply_load(8'h07, 2'b00);
    check_span(97, 112, 7'h07, 1'b0, 7'h00, 1'b0, 1'b0, 1'b1);
    blank_lz = 1'b0;
    check_span(113, 128, 7'h07, 1'b0, 7'h3F, 1'b0, 1'b0, 1'b0);

    // Display disabled for a frame; load still applied and phase kept.
    ack_base = ack_cnt;
    en = 1'b0;
    check_span(129, 135, 7'h00, 1'b0, 7'h00, 1'b0, 1'b1, 1'b1);
    apply_load(8'hC4, 2'b10);
    check_span(136, 144, 7'h00, 1'b0, 7'h00, 1'b0, 1'b1, 1'b1);
    check_output("ack_en_off", 8'(upd_ack), 8'h01);
    en = 1'b1;
    check_span(145, 160, 7'h66, 1'b0, 7'h39, 1'b1, 1'b0, 1'b0);
    check_output("ack_count_en_off", 8'(ack_cnt - ack_base), 8'd1);

    // Common-anode pins and mid-slot asynchronous reset.
    apply_load(8'h8F, 2'b00);
    wait_cycle(180);
    check_output("seg_8f", 8'(seg_out), 8'h71);
    check_output("dig_8f", 8'(dig_sel), 8'h01);
    check_output("seg_ca_8f", 8'(seg_ca), 8'h0E);
    check_output("dig_ca_8f", 8'(dig_ca), 8'h02);
    check_output("dp_ca_8f", 8'(dp_ca), 8'h01);
    #2;
    reset = 1'b1;
    #1;
    check_output("midrst_seg_ca", 8'(seg_ca), 8'h7F);
    check_output("midrst_dig_ca", 8'(dig_ca), 8'h03);
    check_output("midrst_seg", 8'(seg_out), 8'h00);
    check_output("midrst_dig", 8'(dig_sel), 8'h00);
    @(negedge clk);
    reset = 1'b0;
    ack_base = ack_cnt;
    wait_cycle(4);
    check_output("post_rst_seg_ca", 8'(seg_ca), 8'h40);
    check_output("post_rst_dig_ca", 8'(dig_ca), 8'h02);
    check_span(5, 16, 7'h3F, 1'b0, 7'h3F, 1'b0, 1'b0, 1'b0);
    check_output("ack_count_post_rst", 8'(ack_cnt - ack_base), 8'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
